// File: rtl/host_bus_fabric.sv
// Host-bus interconnect: table-driven address decode, per-slave wait states,
// single-shot read/write strobes, open-bus read-data retention and an
// unmapped-access flag.
module host_bus_fabric #(
   parameter int                             P_slaves    = 3,
   parameter int                             P_addr_bits = 16,
   parameter int                             P_data_bits = 8,
   parameter logic [P_slaves*P_addr_bits-1:0] P_map_base = {16'h8000, 16'h2000, 16'h0000},
   parameter logic [P_slaves*P_addr_bits-1:0] P_map_mask = {16'h8000, 16'hE000, 16'hE000},
   parameter logic [P_slaves*4-1:0]          P_wait      = {4'd1, 4'd2, 4'd0},
   parameter bit                             P_open_bus  = 1'b1
) (
   input  logic                            I_clock,
   input  logic                            I_reset,
   input  logic                            I_phy2,
   input  logic                            I_rdwr,
   input  logic [P_addr_bits-1:0]          I_addr,
   input  logic [P_data_bits-1:0]          I_wr_data,
   output logic [P_data_bits-1:0]          O_rd_data,
   output logic                            O_ready,
   output logic [P_slaves-1:0]             O_select,
   output logic [P_slaves-1:0]             O_wren,
   output logic [P_slaves-1:0]             O_rden,
   output logic [P_data_bits-1:0]          O_wr_data,
   input  logic [P_slaves*P_data_bits-1:0] I_rd_data,
   output logic                            O_unmapped
);

   localparam int SEL_W = (P_slaves > 1) ? $clog2(P_slaves) : 1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   sel_valid_q, sel_valid_d;
   logic [P_data_bits-1:0] open_bus_q, open_bus_d;
   logic                   unmapped_q, unmapped_d;

   logic                   hit_any;
   logic [SEL_W-1:0]       hit_idx;
   logic [3:0]             hit_wait;
   logic                   cur_valid;
   logic [SEL_W-1:0]       cur_idx;
   logic                   complete;
   logic [P_data_bits-1:0] slave_data;

   // Priority address decode: scanning downwards lets the lowest index win
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = P_slaves - 1; i >= 0; i--) begin
         if ((I_addr & P_map_mask[i*P_addr_bits +: P_addr_bits]) ==
             (P_map_base[i*P_addr_bits +: P_addr_bits] & P_map_mask[i*P_addr_bits +: P_addr_bits])) begin
            hit_any = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
      hit_wait = P_wait[int'(hit_idx)*4 +: 4];
   end

   // Access FSM: decides stall, which slave is addressed, and the completing clock
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      O_ready     = 1'b1;
      cur_valid   = 1'b0;
      cur_idx     = '0;
      case (state_q)
         ST_IDLE: begin
            if (I_phy2 && hit_any) begin
               cur_valid = 1'b1;
               cur_idx   = hit_idx;
               if (hit_wait != 4'd0) begin
                  O_ready     = 1'b0;
                  state_d     = ST_WAIT;
                  cnt_d       = hit_wait - 4'd1;
                  sel_d       = hit_idx;
                  sel_valid_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!I_phy2) begin
               // Core abandoned the access: no strobe, back to idle
               state_d     = ST_IDLE;
               sel_valid_d = 1'b0;
               cnt_d       = 4'd0;
            end else begin
               // Selection is locked to the slave decoded at access start
               cur_valid = sel_valid_q;
               cur_idx   = sel_q;
               if (cnt_q != 4'd0) begin
                  O_ready = 1'b0;
                  cnt_d   = cnt_q - 4'd1;
               end else begin
                  state_d     = ST_IDLE;
                  sel_valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
         end
      endcase
      // Holding reset suppresses any completion so no strobe can leak out
      complete = I_phy2 & O_ready & ~I_reset;
   end

   // Chip selects, strobes, read-data mux and next open-bus / unmapped values
   always_comb begin
      O_select   = '0;
      O_wren     = '0;
      O_rden     = '0;
      slave_data = I_rd_data[int'(cur_idx)*P_data_bits +: P_data_bits];
      for (int i = 0; i < P_slaves; i++) begin
         if (cur_valid && (cur_idx == SEL_W'(i))) begin
            O_select[i] = 1'b1;
            O_wren[i]   = complete & ~I_rdwr;
            O_rden[i]   = complete & I_rdwr;
         end
      end
      if (cur_valid)
         O_rd_data = slave_data;
      else if (P_open_bus)
         O_rd_data = open_bus_q;
      else
         O_rd_data = '1;
      open_bus_d = open_bus_q;
      if (complete) begin
         if (!I_rdwr)
            open_bus_d = I_wr_data;
         else if (cur_valid)
            open_bus_d = slave_data;
      end
      unmapped_d = complete & ~cur_valid;
   end

   assign O_wr_data  = I_wr_data;
   assign O_unmapped = unmapped_q;

   // State, wait counter, locked selection and open-bus latch registers
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         sel_q       <= '0;
         sel_valid_q <= 1'b0;
         open_bus_q  <= '1;
         unmapped_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         open_bus_q  <= open_bus_d;
         unmapped_q  <= unmapped_d;
      end
   end

endmodule

// File: tb/tb_host_bus_fabric.sv
// Bench for host_bus_fabric with the default three-slave map: directed
// scenarios with literal expectations followed by randomized traffic checked
// every cycle against an access-level behavioural model.
module tb_host_bus_fabric;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        phy2 = 1'b0;
   logic        rdwr = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic [23:0] rd_data = 24'h000000;

   logic [7:0]  o_rd_data, o_wr_data, o0_rd_data, o0_wr_data;
   logic        o_ready, o_unmapped, o0_ready, o0_unmapped;
   logic [2:0]  o_select, o_wren, o_rden, o0_select, o0_wren, o0_rden;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   host_bus_fabric dut (
      .I_clock(clk), .I_reset(rst), .I_phy2(phy2), .I_rdwr(rdwr), .I_addr(addr),
      .I_wr_data(wdata), .O_rd_data(o_rd_data), .O_ready(o_ready), .O_select(o_select),
      .O_wren(o_wren), .O_rden(o_rden), .O_wr_data(o_wr_data), .I_rd_data(rd_data),
      .O_unmapped(o_unmapped));

   host_bus_fabric #(.P_open_bus(1'b0)) dut0 (
      .I_clock(clk), .I_reset(rst), .I_phy2(phy2), .I_rdwr(rdwr), .I_addr(addr),
      .I_wr_data(wdata), .O_rd_data(o0_rd_data), .O_ready(o0_ready), .O_select(o0_select),
      .O_wren(o0_wren), .O_rden(o0_rden), .O_wr_data(o0_wr_data), .I_rd_data(rd_data),
      .O_unmapped(o0_unmapped));

   // Memory map of the default configuration
   int map_base [3] = '{32'h0000, 32'h2000, 32'h8000};
   int map_mask [3] = '{32'hE000, 32'hE000, 32'h8000};
   int map_wait [3] = '{0, 2, 1};

   function automatic int decode(input logic [15:0] a);
      for (int i = 0; i < 3; i++)
         if ((int'(a) & map_mask[i]) == (map_base[i] & map_mask[i])) return i;
      return -1;
   endfunction

   // Model state: is an access stalled, how many stall clocks so far, which slave
   bit         m_busy = 1'b0;
   int         m_age  = 0;
   int         m_sel  = 0;
   logic [7:0] m_ob   = 8'hFF;
   logic       m_unm  = 1'b0;

   function automatic int exp_idx();
      if (!phy2) return -1;
      if (m_busy) return m_sel;
      return decode(addr);
   endfunction

   function automatic logic exp_rdy();
      int k;
      if (!phy2) return 1'b1;
      if (m_busy) return (m_age >= map_wait[m_sel]);
      k = decode(addr);
      if (k < 0) return 1'b1;
      return (map_wait[k] == 0);
   endfunction

   function automatic logic [7:0] slice(input int k);
      return rd_data[k*8 +: 8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model advance: one access = (wait) stall clocks then one completion
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_age <= 0; m_sel <= 0; m_ob <= 8'hFF; m_unm <= 1'b0;
      end else begin
         int  k;
         logic r;
         k = exp_idx();
         r = exp_rdy();
         m_unm <= phy2 && r && (k < 0);
         if (phy2 && r) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            if (!rdwr) m_ob <= wdata;
            else if (k >= 0) m_ob <= slice(k);
         end else if (phy2) begin
            if (!m_busy) begin
               m_busy <= 1'b1; m_sel <= k; m_age <= 1;
            end else begin
               m_age <= m_age + 1;
            end
         end else begin
            m_busy <= 1'b0;
            m_age  <= 0;
         end
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (!rst) begin
         int         k;
         logic       r, c;
         logic [2:0] s;
         logic [7:0] rd1, rd0;
         k   = exp_idx();
         r   = exp_rdy();
         c   = phy2 && r;
         s   = (k >= 0) ? 3'(1 << k) : 3'b000;
         rd1 = (k >= 0) ? slice(k) : m_ob;
         rd0 = (k >= 0) ? slice(k) : 8'hFF;
         check("m_ready",    32'(o_ready),    32'(r));
         check("m_select",   32'(o_select),   32'(s));
         check("m_wren",     32'(o_wren),     32'((c && !rdwr) ? s : 3'b000));
         check("m_rden",     32'(o_rden),     32'((c && rdwr) ? s : 3'b000));
         check("m_rd_data",  32'(o_rd_data),  32'(rd1));
         check("m_unmapped", 32'(o_unmapped), 32'(m_unm));
         check("m_wr_data",  32'(o_wr_data),  32'(wdata));
         check("m0_ready",   32'(o0_ready),   32'(r));
         check("m0_rd_data", 32'(o0_rd_data), 32'(rd0));
         check("m0_strobes", 32'({o0_wren, o0_rden}), 32'({o_wren, o_rden}));
         check("m0_unmapped", 32'(o0_unmapped), 32'(m_unm));
      end
   end

   task automatic drive(input logic p, input logic r, input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      phy2 = p; rdwr = r; addr = a; wdata = d;
      @(negedge clk);
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 4))
         0: return 16'($urandom_range(0, 16'h1FFF));
         1: return 16'(16'h2000 + $urandom_range(0, 16'h1FFF));
         2: return 16'(16'h4000 + $urandom_range(0, 16'h3FFF));
         3: return 16'(16'h8000 + $urandom_range(0, 16'h7FFF));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      bit hold;
      // Reset state
      @(negedge clk);
      check("rst_ready",    32'(o_ready),    32'h1);
      check("rst_select",   32'(o_select),   32'h0);
      check("rst_unmapped", 32'(o_unmapped), 32'h0);
      check("rst_rd_data",  32'(o_rd_data),  32'hFF);
      check("rst_strobes",  32'({o_wren, o_rden}), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      rd_data = {8'h3C, 8'h80, 8'h11};

      // 1: zero-wait RAM write
      drive(1'b1, 1'b0, 16'h0123, 8'h55);
      check("t1_ready", 32'(o_ready), 32'h1);
      check("t1_wren",  32'(o_wren),  32'b001);
      drive(1'b0, 1'b1, 16'h0123, 8'h00);
      check("t1_wren_off", 32'(o_wren), 32'b000);
      drive(1'b1, 1'b1, 16'h4016, 8'h00);
      check("t1_latch", 32'(o_rd_data), 32'h55);
      drive(1'b0, 1'b1, 16'h4016, 8'h00);
      check("t1_unmapped", 32'(o_unmapped), 32'h1);

      // 2: PPU read with two stall clocks
      drive(1'b1, 1'b1, 16'h2002, 8'h00);
      check("t2_c1_ready", 32'(o_ready), 32'h0);
      check("t2_c1_rden",  32'(o_rden),  32'b000);
      check("t2_c1_sel",   32'(o_select), 32'b010);
      drive(1'b1, 1'b1, 16'h2002, 8'h00);
      check("t2_c2_ready", 32'(o_ready), 32'h0);
      check("t2_c2_rden",  32'(o_rden),  32'b000);
      drive(1'b1, 1'b1, 16'h2002, 8'h00);
      check("t2_c3_ready", 32'(o_ready), 32'h1);
      check("t2_c3_rden",  32'(o_rden),  32'b010);
      check("t2_c3_data",  32'(o_rd_data), 32'h80);
      drive(1'b0, 1'b1, 16'h2002, 8'h00);
      check("t2_rden_off", 32'(o_rden), 32'b000);

      // 3: unmapped read returns open bus / all-ones
      drive(1'b1, 1'b1, 16'h4016, 8'h00);
      check("t3_openbus", 32'(o_rd_data),  32'h80);
      check("t3_ones",    32'(o0_rd_data), 32'hFF);
      check("t3_strobes", 32'({o_wren, o_rden, o_select}), 32'h0);
      drive(1'b0, 1'b1, 16'h4016, 8'h00);
      check("t3_unm_hi", 32'(o_unmapped), 32'h1);
      drive(1'b0, 1'b1, 16'h4016, 8'h00);
      check("t3_unm_lo", 32'(o_unmapped), 32'h0);

      // 4: address change during WAIT does not reselect
      drive(1'b1, 1'b1, 16'h8000, 8'h00);
      check("t4_c1_sel",   32'(o_select), 32'b100);
      check("t4_c1_ready", 32'(o_ready),  32'h0);
      drive(1'b1, 1'b1, 16'h0000, 8'h00);
      check("t4_c2_sel",  32'(o_select),  32'b100);
      check("t4_c2_rden", 32'(o_rden),    32'b100);
      check("t4_c2_data", 32'(o_rd_data), 32'h3C);
      drive(1'b0, 1'b1, 16'h0000, 8'h00);

      // 5: asynchronous reset in WAIT of a PPU write
      drive(1'b1, 1'b0, 16'h2000, 8'h77);
      check("t5_c1_ready", 32'(o_ready), 32'h0);
      drive(1'b1, 1'b0, 16'h2000, 8'h77);
      @(posedge clk); #1;
      rst = 1'b1; phy2 = 1'b0;
      @(negedge clk);
      check("t5_ready", 32'(o_ready), 32'h1);
      check("t5_wren",  32'(o_wren),  32'b000);
      check("t5_sel",   32'(o_select), 32'b000);
      @(posedge clk); #1 rst = 1'b0;
      drive(1'b1, 1'b1, 16'h4016, 8'h00);
      check("t5_latch", 32'(o_rd_data), 32'hFF);
      drive(1'b0, 1'b1, 16'h4016, 8'h00);

      // 6: abort in WAIT of a PPU read, then a fresh access from IDLE
      drive(1'b1, 1'b1, 16'h2007, 8'h00);
      check("t6_c1_ready", 32'(o_ready), 32'h0);
      drive(1'b0, 1'b1, 16'h2007, 8'h00);
      check("t6_ab_rden",  32'(o_rden),  32'b000);
      check("t6_ab_ready", 32'(o_ready), 32'h1);
      drive(1'b1, 1'b1, 16'h2007, 8'h00);
      check("t6_new_ready", 32'(o_ready), 32'h0);
      check("t6_new_rden",  32'(o_rden),  32'b000);
      drive(1'b1, 1'b1, 16'h2007, 8'h00);
      drive(1'b1, 1'b1, 16'h2007, 8'h00);
      check("t6_done_rden", 32'(o_rden), 32'b010);
      drive(1'b0, 1'b1, 16'h2007, 8'h00);

      // Randomized traffic, mostly holding inputs while a stall is in progress
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rd_data = 24'($urandom);
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            rst  = 1'b1;
            phy2 = 1'b0;
         end else begin
            hold = phy2 && ($urandom_range(0, 3) != 0);
            if (!hold) begin
               phy2  = ($urandom_range(0, 3) != 0);
               rdwr  = 1'($urandom_range(0, 1));
               addr  = pick_addr();
               wdata = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
               addr = pick_addr();
            end
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; phy2 = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
